spi_burst_sequencer: RTL
========================

# spi_burst_sequencer

Hardware MMIO master sitting directly upstream of `spi_mmio_gpio_cs`. It runs the peripheral's software burst protocol without CPU involvement:
- one-time configuration after reset;
- assert CS with DC through the GPIO register;
- poll STATUS.READY and write TXRX for each byte of a valid/ready byte stream;
- wait for the final READY, then deassert CS.

It frees the core from byte-level polling when streaming command and data bursts to SPI displays.

## Interface
Parameters:
- ADDR_W, 12, MMIO address width; matches the peripheral.
- REG_TXRX / REG_STATUS / REG_CTRL / REG_CLKDIV / REG_GPIO, 'h000 / 'h004 / 'h008 / 'h00C / 'h010, peripheral register offsets.
- CLKDIV_INIT, 1, value written to CLKDIV during init.
- POS_EDGE, 1, CTRL bit0 value written during init.
- POLL_MAX, 1024, maximum consecutive STATUS reads before a timeout abort (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  upstream byte valid.
- s_ready  out  1  upstream byte accept.
- s_data  in  8  byte to transmit.
- s_dc  in  1  DC level for the burst; sampled on the first byte only.
- s_last  in  1  marks the final byte of a burst.
- m_mmio_valid  out  1  MMIO request valid.
- m_mmio_ready  in  1  MMIO request accepted (read data valid in the same cycle).
- m_mmio_we  out  1  1 = write, 0 = read.
- m_mmio_addr  out  ADDR_W  register address.
- m_mmio_wdata  out  32  write data.
- m_mmio_wstrb  out  4  byte strobes: 'hF on writes, 0 on reads.
- m_mmio_rdata  in  32  read data.
- init_done  out  1  high once configuration writes have completed.
- busy  out  1  high from first-byte accept until the CS-high write completes.
- done  out  1  one-cycle pulse when a burst ends normally.
- err  out  1  one-cycle pulse on a poll timeout abort.

## Operation
- GPIO word = {29'b0, res_n, dc, cs_n}. CTRL word = 'h100 | (1<<1) | POS_EDGE (EN, width8, edge).
- FSM states: INIT_CLKDIV → INIT_CTRL → INIT_GPIO → IDLE → CS_LO → POLL → TX → (FETCH → POLL)* → FPOLL → CS_HI → IDLE.
- Init sequence, written once after reset:
  - INIT_CLKDIV writes CLKDIV_INIT.
  - INIT_CTRL writes the CTRL word.
  - INIT_GPIO writes GPIO = 'b111.
  - init_done rises when the INIT_GPIO handshake completes.
- IDLE: s_ready=1. On accept, latch s_data, s_last and dc←s_dc; go to CS_LO.
- CS_LO: write GPIO = {res_n=1, dc, cs_n=0}.
- POLL: read STATUS.
  - rdata[0]=1 → TX.
  - Otherwise repeat the read and increment the poll counter.
- TX: write TXRX = {24'h0, byte}.
  - If the latched last=1 → FPOLL.
  - Otherwise → FETCH.
- FETCH: s_ready=1. On accept, latch data and last (s_dc ignored); go to POLL.
- FPOLL: read STATUS until rdata[0]=1, then go to CS_HI.
- CS_HI: write GPIO = 'b111 (cs_n=1, dc=1, res_n=1). On handshake, pulse done and go to IDLE.
- Poll counter:
  - Clears on every state entry into POLL or FPOLL.
  - If POLL_MAX reads all return READY=0, pulse err and go to CS_HI.
  - No done pulse on this path; remaining bytes of the burst are accepted and discarded in IDLE until s_last.
- s_ready is 0 in every state except IDLE and FETCH (after init) and the discard mode.

## Timing
- Reset values:
  - m_mmio_valid=0; we, addr, wdata, wstrb = 0.
  - s_ready=0, init_done=0, busy=0, done=0, err=0.
  - FSM = INIT_CLKDIV.
- Reset is asynchronous at any point, including mid-burst. The block does not restore CS itself; the peripheral's own reset returns CS high.
- MMIO rules:
  - m_mmio_valid rises the cycle after entering an MMIO state.
  - While valid=1, addr/we/wdata/wstrb are held stable until m_mmio_ready=1.
  - rdata is sampled in the handshake cycle.
  - valid is low for exactly one cycle between consecutive transactions.
- Per-byte minimum with a zero-wait slave, READY already set: 4 cycles (read, gap, write, gap).
- busy rises in the cycle after the IDLE accept. It falls in the same cycle that done or the abort-path CS_HI handshake completes.
- A byte offered while s_ready=0 stays pending; the upstream must hold s_valid and s_data stable.

## Test plan
- Reset release with an always-ready slave → writes CLKDIV=1, CTRL='h103, GPIO='h7 in order; init_done=1 after the third handshake.
- Burst AE,A1,C8,AF with dc=0 → CS_LO write GPIO='h4, four STATUS-read/TXRX-write pairs, FPOLL, GPIO='h7, one done pulse; an SPI sniffer on a real peripheral captures AE A1 C8 AF.
- Burst 00..77 (8 bytes) with dc=1, s_dc toggled on bytes 2–8 → CS_LO GPIO='h6 only, dc never changes, 8 TXRX writes with correct data.
- STATUS returns READY=0 for 5 reads, then 1 → exactly 6 STATUS reads precede that TXRX write; m_mmio_addr stable while valid is stalled by ready=0 for 3 cycles.
- POLL_MAX=4, STATUS stuck at 0 → 4 reads, err pulse, GPIO='h7 write, no done, remaining burst bytes drained through s_last.
- Async reset asserted during POLL of byte 2 → all outputs zero immediately; after release, the init sequence repeats.

Source files
------------

// File: rtl/spi_burst_sequencer.sv
// MMIO master for spi_mmio_gpio_cs: configures the peripheral once after reset, then streams
// valid/ready byte bursts through it (CS/DC via GPIO, STATUS.READY polling, TXRX writes).
module spi_burst_sequencer #(
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] REG_TXRX    = 'h000,
    parameter logic [ADDR_W-1:0] REG_STATUS  = 'h004,
    parameter logic [ADDR_W-1:0] REG_CTRL    = 'h008,
    parameter logic [ADDR_W-1:0] REG_CLKDIV  = 'h00C,
    parameter logic [ADDR_W-1:0] REG_GPIO    = 'h010,
    parameter logic [31:0]       CLKDIV_INIT = 32'd1,
    parameter bit                POS_EDGE    = 1'b1,
    parameter int                POLL_MAX    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_dc,
    input  logic              s_last,
    output logic              m_mmio_valid,
    input  logic              m_mmio_ready,
    output logic              m_mmio_we,
    output logic [ADDR_W-1:0] m_mmio_addr,
    output logic [31:0]       m_mmio_wdata,
    output logic [3:0]        m_mmio_wstrb,
    input  logic [31:0]       m_mmio_rdata,
    output logic              init_done,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int          CNT_W     = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
    localparam logic [31:0] CTRL_WORD = 32'h100 | 32'h2 | 32'(POS_EDGE);
    localparam logic [31:0] GPIO_IDLE = 32'h7;

    typedef enum logic [3:0] {
        ST_INIT_CLKDIV, ST_INIT_CTRL, ST_INIT_GPIO, ST_IDLE, ST_CS_LO,
        ST_POLL, ST_TX, ST_FETCH, ST_FPOLL, ST_CS_HI
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid;
    logic [CNT_W-1:0]   r_poll_cnt;
    logic [7:0]         r_byte;
    logic               r_last;
    logic               r_dc;
    logic               r_abort;
    logic               r_discard;
    logic               r_init_done;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_hs;
    logic               w_accept;
    logic               w_ready_bit;
    logic               w_poll_last;
    logic               w_timeout;
    logic               w_poll_entry;
    logic               w_mmio_state;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [31:0]        w_wdata;
    logic               w_unused_rdata;

    assign w_hs           = r_valid & m_mmio_ready;
    assign s_ready        = (r_state == ST_IDLE) || (r_state == ST_FETCH);
    assign w_accept       = s_valid & s_ready;
    assign w_ready_bit    = m_mmio_rdata[0];
    assign w_unused_rdata = ^m_mmio_rdata[31:1];
    assign w_poll_last    = (r_poll_cnt == CNT_W'(POLL_MAX - 1));
    assign w_poll_entry   = (w_state_nxt != r_state) &&
                            ((w_state_nxt == ST_POLL) || (w_state_nxt == ST_FPOLL));

    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_INIT_CLKDIV: if (w_hs) w_state_nxt = ST_INIT_CTRL;
            ST_INIT_CTRL:   if (w_hs) w_state_nxt = ST_INIT_GPIO;
            ST_INIT_GPIO:   if (w_hs) w_state_nxt = ST_IDLE;
            ST_IDLE:        if (w_accept && !r_discard) w_state_nxt = ST_CS_LO;
            ST_CS_LO:       if (w_hs) w_state_nxt = ST_POLL;
            ST_POLL, ST_FPOLL: begin
                if (w_hs) begin
                    if (w_ready_bit) begin
                        w_state_nxt = (r_state == ST_POLL) ? ST_TX : ST_CS_HI;
                    end else if (w_poll_last) begin
                        w_state_nxt = ST_CS_HI;
                        w_timeout   = 1'b1;
                    end
                end
            end
            ST_TX:          if (w_hs) w_state_nxt = r_last ? ST_FPOLL : ST_FETCH;
            ST_FETCH:       if (w_accept) w_state_nxt = ST_POLL;
            ST_CS_HI:       if (w_hs) w_state_nxt = ST_IDLE;
            default:        w_state_nxt = ST_INIT_CLKDIV;
        endcase
    end

    // Request contents are a pure function of state and latched data, so they hold during stalls.
    always_comb begin
        w_mmio_state = 1'b1;
        w_we         = 1'b1;
        w_addr       = '0;
        w_wdata      = '0;
        case (r_state)
            ST_INIT_CLKDIV: begin w_addr = REG_CLKDIV; w_wdata = CLKDIV_INIT; end
            ST_INIT_CTRL:   begin w_addr = REG_CTRL;   w_wdata = CTRL_WORD;   end
            ST_INIT_GPIO:   begin w_addr = REG_GPIO;   w_wdata = GPIO_IDLE;   end
            ST_CS_LO:       begin w_addr = REG_GPIO;   w_wdata = {29'b0, 1'b1, r_dc, 1'b0}; end
            ST_POLL, ST_FPOLL: begin w_we = 1'b0; w_addr = REG_STATUS; end
            ST_TX:          begin w_addr = REG_TXRX;   w_wdata = {24'h0, r_byte}; end
            ST_CS_HI:       begin w_addr = REG_GPIO;   w_wdata = GPIO_IDLE;   end
            default:        begin w_mmio_state = 1'b0; w_we = 1'b0; end
        endcase
    end

    assign m_mmio_valid = r_valid;
    assign m_mmio_we    = r_valid & w_we;
    assign m_mmio_addr  = r_valid ? w_addr : '0;
    assign m_mmio_wdata = r_valid ? w_wdata : '0;
    assign m_mmio_wstrb = (r_valid & w_we) ? 4'hF : 4'h0;
    assign init_done    = r_init_done;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

    // NOTE: registers use non-blocking assignments so every update samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT_CLKDIV;
            r_valid     <= 1'b0;
            r_poll_cnt  <= '0;
            r_byte      <= '0;
            r_last      <= 1'b0;
            r_dc        <= 1'b0;
            r_abort     <= 1'b0;
            r_discard   <= 1'b0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // A FETCH accept doubles as the inter-transaction gap so the next STATUS read starts at once.
            r_valid <= (w_mmio_state && !w_hs) || ((r_state == ST_FETCH) && w_accept);
            r_done  <= 1'b0;
            r_err   <= 1'b0;

            if (w_poll_entry) begin
                r_poll_cnt <= '0;
            end else if (w_hs && !w_we && !w_ready_bit) begin
                r_poll_cnt <= r_poll_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                if ((r_state == ST_IDLE) && r_discard) begin
                    if (s_last) r_discard <= 1'b0;
                end else begin
                    r_byte <= s_data;
                    r_last <= s_last;
                    if (r_state == ST_IDLE) begin
                        r_dc    <= s_dc;
                        r_busy  <= 1'b1;
                        r_abort <= 1'b0;
                    end
                end
            end

            // Bytes still owed by the upstream after an abort are swallowed in IDLE up to s_last.
            if (w_timeout) begin
                r_err     <= 1'b1;
                r_abort   <= 1'b1;
                r_discard <= (r_state == ST_POLL) && !r_last;
            end

            if ((r_state == ST_INIT_GPIO) && w_hs) r_init_done <= 1'b1;

            if ((r_state == ST_CS_HI) && w_hs) begin
                r_busy <= 1'b0;
                r_done <= !r_abort;
            end
        end
    end
endmodule
